// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings for both directions and
// the minimum supported bit period.
package uart_pkg;

  localparam int unsigned UART_MIN_BAUD_DIV = 4;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_t;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. The pointers carry an extra wrap bit
// so that full and empty can be told apart.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0] PtrOne = 1;

  logic [AddrW:0]          wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                    rd_en, wr_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign rd_en   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot being written, so full does not block.
  assign wr_en   = push_i && (!full_o || rd_en);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser sampling a synchronised line at mid-bit,
// feeding good bytes into a FWFT FIFO and pulsing framing/overrun faults.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [15:0]           baud_div_i,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_ren_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  logic                  sync1_q, rx_s;
  rx_state_t             state_q, state_d;
  logic [15:0]           baud_cnt_q, baud_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  cnt_clr, push, mid_hit, end_hit;

  // Two-flop synchroniser; idles high so reset looks like an idle line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_bit_i;
      rx_s    <= sync1_q;
    end
  end

  assign mid_hit = (baud_cnt_q == (baud_div_i >> 1));
  assign end_hit = (baud_cnt_q == (baud_div_i - 16'd1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (rx_en_i && !rx_s) state_d = RxStart;
      end
      RxStart: begin
        if (mid_hit) begin
          if (!rx_s) begin
            state_d   = RxData;
            bit_cnt_d = '0;
          end else begin
            state_d = RxIdle;
          end
        end
      end
      RxData: begin
        if (end_hit) begin
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LastBit) begin
            state_d = RxStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            cnt_clr   = 1'b1;
          end
        end
      end
      RxStop: begin
        if (end_hit) begin
          state_d = RxIdle;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (full_o && !rx_ren_i) begin
            overrun_d = 1'b1;
          end else begin
            // Full with a concurrent pop still accepts the byte.
            push = 1'b1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
    baud_cnt_d = (cnt_clr || (state_d != state_q)) ? '0 : baud_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RxIdle;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  uart_rx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .wdata_i(shift_q),
    .pop_i  (rx_ren_i),
    .rdata_o(dout_o),
    .empty_o(empty_o),
    .full_o (full_o)
  );

  baud_div_min_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != RxIdle) |-> (baud_div_i >= 16'(UART_MIN_BAUD_DIV)));

endmodule
